// File: rtl/aes_key_expander_seq.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per clock, stored locally, read per round.
// Optional build macro KEYEXP_ZEROIZE_EN adds a zeroize input that wipes the stored schedule.
//
// state  | meaning
// IDLE   | no schedule loaded since reset (or zeroize)
// EXPAND | generating w[i], one word per edge
// READY  | schedule complete, rk_o serves round keys
module aes_key_expander_seq #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef KEYEXP_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic [NK*32-1:0] key_i,
  input  logic [3:0]       rk_idx,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  output logic [127:0]     rk_o
);

  localparam int NR = NK + 6;
  localparam int TW = 4 * (NR + 1);
  localparam logic [5:0] TW_LAST = 6'(TW - 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_W    = 4'(NR);

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_key_expander_seq: NK must be 4, 6 or 8");
    end
  endgenerate

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t      state_q;
  logic [31:0] w_q [TW];
  logic [5:0]  i_q;
  logic [2:0]  kmod_q;
  logic [7:0]  rcon_q;
  logic        busy_q;
  logic        done_q;
  logic        valid_q;

  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t_word;
  logic [31:0] w_new;
  logic [7:0]  rcon_d;

  // One shared SubWord: the rotated word on kmod==0, the plain word for the AES-256 mid-step.
  always_comb begin
    w_prev  = w_q[i_q - 6'd1];
    w_back  = w_q[i_q - NK_W];
    sub_in  = (kmod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = subword(sub_in);
    if (kmod_q == 3'd0) begin
      t_word = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && kmod_q == 3'd4) begin
      t_word = sub_out;
    end else begin
      t_word = w_prev;
    end
    w_new  = w_back ^ t_word;
    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      kmod_q  <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int k = 0; k < TW; k++) w_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
      if (zeroize) begin
        state_q <= IDLE;
        i_q     <= '0;
        kmod_q  <= '0;
        rcon_q  <= 8'h01;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
        for (int k = 0; k < TW; k++) w_q[k] <= '0;
      end else begin
`else
      begin
`endif
        unique case (state_q)
          IDLE, READY: begin
            if (start) begin
              for (int k = 0; k < NK; k++) w_q[k] <= key_i[NK*32-1-32*k -: 32];
              state_q <= EXPAND;
              i_q     <= NK_W;
              kmod_q  <= '0;
              rcon_q  <= 8'h01;
              busy_q  <= 1'b1;
              valid_q <= 1'b0;
            end
          end
          EXPAND: begin
            w_q[i_q] <= w_new;
            i_q      <= i_q + 6'd1;
            kmod_q   <= (kmod_q == NK_LAST) ? 3'd0 : kmod_q + 3'd1;
            if (kmod_q == 3'd0) rcon_q <= rcon_d;
            if (i_q == TW_LAST) begin
              state_q <= READY;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [5:0] rk_base;

  always_comb begin
    rk_base = {rk_idx, 2'b00};
    rk_o    = '0;
    if (valid_q && rk_idx <= NR_W) begin
      rk_o = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = valid_q;

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Bench for aes_key_expander_seq: NK=4/6/8 instances, scoreboard fed from an arithmetic key-schedule model.
`timescale 1ns/1ps
module tb_aes_key_expander_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [3:0]   idx4, idx6, idx8;
  logic         busy4, busy6, busy8;
  logic         done4, done6, done8;
  logic         valid4, valid6, valid8;
  logic [127:0] rk4, rk6, rk8;
`ifdef KEYEXP_ZEROIZE_EN
  logic         zero4;
`endif

  aes_key_expander_seq #(.NK(4)) u_nk4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef KEYEXP_ZEROIZE_EN
    .zeroize(zero4),
`endif
    .key_i(key4), .rk_idx(idx4), .busy(busy4), .done(done4), .keys_valid(valid4), .rk_o(rk4));

  aes_key_expander_seq #(.NK(6)) u_nk6 (
    .clk(clk), .rst_n(rst_n), .start(start6),
`ifdef KEYEXP_ZEROIZE_EN
    .zeroize(1'b0),
`endif
    .key_i(key6), .rk_idx(idx6), .busy(busy6), .done(done6), .keys_valid(valid6), .rk_o(rk6));

  aes_key_expander_seq #(.NK(8)) u_nk8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
`ifdef KEYEXP_ZEROIZE_EN
    .zeroize(1'b0),
`endif
    .key_i(key8), .rk_idx(idx8), .busy(busy8), .done(done8), .keys_valid(valid8), .rk_o(rk8));

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KALT = 256'h000102030405060708090a0b0c0d0e0f;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic [127:0] sb_q[$];
  logic [7:0]   sbt [256];
  logic [31:0]  mw [60];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference S-box from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sw(input logic [31:0] x);
    return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
  endfunction

  function automatic void model_expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    int          tw;
    tw = 4 * (nk + 7);
    rc = 8'h01;
    for (int k = 0; k < nk; k++) mw[k] = key[nk*32-1-32*k -: 32];
    for (int k = nk; k < tw; k++) begin
      t = mw[k-1];
      if (k % nk == 0) begin
        t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && k % nk == 4) begin
        t = sw(t);
      end
      mw[k] = mw[k-nk] ^ t;
    end
  endfunction

  function automatic logic get_done(input int nk);
    case (nk) 4: return done4; 6: return done6; default: return done8; endcase
  endfunction
  function automatic logic get_busy(input int nk);
    case (nk) 4: return busy4; 6: return busy6; default: return busy8; endcase
  endfunction
  function automatic logic get_valid(input int nk);
    case (nk) 4: return valid4; 6: return valid6; default: return valid8; endcase
  endfunction
  function automatic logic [127:0] get_rk(input int nk);
    case (nk) 4: return rk4; 6: return rk6; default: return rk8; endcase
  endfunction

  task automatic set_start(input int nk, input logic v);
    case (nk) 4: start4 = v; 6: start6 = v; default: start8 = v; endcase
  endtask
  task automatic set_key(input int nk, input logic [255:0] k);
    case (nk) 4: key4 = k[127:0]; 6: key6 = k[191:0]; default: key8 = k; endcase
  endtask
  task automatic set_idx(input int nk, input int r);
    case (nk) 4: idx4 = 4'(r); 6: idx6 = 4'(r); default: idx8 = 4'(r); endcase
  endtask

  task automatic start_expand(input int nk, input logic [255:0] key, input bit push);
    @(negedge clk);
    set_key(nk, key);
    set_start(nk, 1'b1);
    if (push) begin
      model_expand(nk, key);
      for (int r = 0; r <= nk + 6; r++) sb_q.push_back({mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
    end
    @(posedge clk);
    #1;
    set_start(nk, 1'b0);
    t0 = cyc;
  endtask

  task automatic wait_done(input int nk, input int exp_lat, input string tag);
    int lim;
    lim = cyc + 200;
    while (!get_done(nk) && cyc < lim) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_latency"}, 128'(cyc - t0 + 1), 128'(exp_lat));
    check({tag, "_busy_at_done"}, 128'(get_busy(nk)), 128'(0));
    check({tag, "_valid_at_done"}, 128'(get_valid(nk)), 128'(1));
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 128'(get_done(nk)), 128'(0));
  endtask

  task automatic check_keys(input int nk, input string tag);
    logic [127:0] exp;
    for (int r = 0; r < 16; r++) begin
      set_idx(nk, r);
      #1;
      exp = (r <= nk + 6) ? sb_q.pop_front() : 128'h0;
      check($sformatf("%s_rk%0d", tag, r), get_rk(nk), exp);
    end
  endtask

  task automatic check_rk(input int nk, input int r, input logic [127:0] exp, input string tag);
    set_idx(nk, r);
    #1;
    check(tag, get_rk(nk), exp);
  endtask

  initial begin
    int pulses;
    for (int b = 0; b < 256; b++) sbt[b] = ref_sbox(8'(b));
    rst_n  = 1'b0;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    idx4 = '0; idx6 = '0; idx8 = '0;
`ifdef KEYEXP_ZEROIZE_EN
    zero4 = 1'b0;
`endif
    #22;
    check("rst_busy", 128'({busy4, busy6, busy8}), 128'(0));
    check("rst_done", 128'({done4, done6, done8}), 128'(0));
    check("rst_valid", 128'({valid4, valid6, valid8}), 128'(0));
    check("rst_rk4", rk4, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    start_expand(4, K128, 1'b1);
    check("t1_busy", 128'(busy4), 128'(1));
    check("t1_valid_low", 128'(valid4), 128'(0));
    wait_done(4, 41, "t1");
    check_keys(4, "t1");
    check_rk(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "t1_fips_rk10");
    check_rk(4, 0, K128[127:0], "t1_fips_rk0");

    start_expand(6, K192, 1'b1);
    wait_done(6, 47, "t2");
    check_keys(6, "t2");
    check_rk(6, 12, 128'he98ba06f448c773c8ecc720401002202, "t2_fips_rk12");

    start_expand(8, K256, 1'b1);
    wait_done(8, 53, "t3");
    check_keys(8, "t3");
    check_rk(8, 14, 128'hfe4890d1e6188d0b046df344706c631e, "t3_fips_rk14");

    // start with a different key while expanding must be ignored
    start_expand(4, K128, 1'b1);
    repeat (19) @(posedge clk);
    @(negedge clk);
    key4   = KALT[127:0];
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    check("t4_busy_after_restart_try", 128'(busy4), 128'(1));
    wait_done(4, 41, "t4");
    check_keys(4, "t4");

    start_expand(4, KALT, 1'b1);
    check("t4b_valid_drop", 128'(valid4), 128'(0));
    check("t4b_busy", 128'(busy4), 128'(1));
    check_rk(4, 0, 128'h0, "t4b_rk0_hidden");
    repeat (10) @(posedge clk);
    check_rk(4, 5, 128'h0, "t4b_rk5_hidden");
    wait_done(4, 41, "t4b");
    check_keys(4, "t4b");

    // asynchronous reset aborts an expansion
    start_expand(4, K128, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 128'(busy4), 128'(0));
    check("t5_valid", 128'(valid4), 128'(0));
    check("t5_done", 128'(done4), 128'(0));
    for (int r = 0; r < 16; r++) check_rk(4, r, 128'h0, $sformatf("t5_rk%0d", r));
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done4) pulses++;
    end
    check("t5_no_done", 128'(pulses), 128'(0));
    check("t5_valid_after", 128'(valid4), 128'(0));
    start_expand(4, K128, 1'b1);
    wait_done(4, 41, "t5b");
    check_keys(4, "t5b");

`ifdef KEYEXP_ZEROIZE_EN
    @(negedge clk);
    zero4  = 1'b1;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    zero4  = 1'b0;
    start4 = 1'b0;
    check("z_busy", 128'(busy4), 128'(0));
    check("z_valid", 128'(valid4), 128'(0));
    check_rk(4, 0, 128'h0, "z_rk0");
    @(posedge clk);
    #1;
    check("z_stays_idle", 128'(busy4), 128'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
